// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: streams WIDTH-bit operands LSB-first through an external 1-bit ALU slice.
// Optional zero flag output enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [2:0]       alu_m,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  input  logic             alu_out,
  input  logic             alu_next,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only while busy=0; a request made while busy=1 is
  // dropped, not queued. done is a one-cycle pulse that ends the busy window.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [2:0]       m_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_next;

  assign res_next  = {alu_out, res_sh[WIDTH-1:1]};
  assign state_dbg = state;

  always_comb begin
    alu_m = 3'b000;
    alu_a = 1'b0;
    alu_b = 1'b0;
    alu_c = 1'b0;
    if (state == RUN) begin
      alu_m = m_reg;
      alu_a = a_sh[0];
      alu_b = b_sh[0];
      alu_c = (m_reg == 3'b000) ? carry : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      m_reg  <= 3'b000;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (M <= 3'b100) begin
              a_sh  <= a_in;
              b_sh  <= b_in;
              m_reg <= M;
              carry <= (M == 3'b000) ? cin : 1'b0;
              cnt   <= '0;
              state <= RUN;
            end else begin
              // Illegal mode: report immediately, keep the previous result.
              cout  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= alu_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= res_next;
            cout   <= (m_reg == 3'b000) ? alu_next : 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero   <= (res_next == '0);
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with a behavioural 1-bit ALU slice.
// Zero-flag checks compile in when SERIAL_ALU_ZERO_FLAG_EN is defined.
module tb_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] m = 3'b000;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       cin = 1'b0;
  logic [2:0] alu_m;
  logic       alu_a, alu_b, alu_c, alu_out, alu_next;
  logic [7:0] result;
  logic       cout, busy, done, err;
  logic [1:0] state_dbg;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic       zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .M(m), .a_in(a), .b_in(b), .cin(cin),
    .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_out(alu_out), .alu_next(alu_next),
    .result(result), .cout(cout), .busy(busy), .done(done), .err(err),
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    .zero(zero),
`endif
    .state_dbg(state_dbg)
  );

  // External 1-bit ALU slice.
  always_comb begin
    alu_out  = 1'b0;
    alu_next = 1'b0;
    case (alu_m)
      3'b000: begin
        alu_out  = alu_a ^ alu_b ^ alu_c;
        alu_next = (alu_a & alu_b) | (alu_a & alu_c) | (alu_b & alu_c);
      end
      3'b001:  alu_out = alu_a & alu_b;
      3'b010:  alu_out = alu_a | alu_b;
      3'b011:  alu_out = alu_a ^ alu_b;
      3'b100:  alu_out = ~(alu_a ^ alu_b);
      default: alu_out = 1'b0;
    endcase
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issues one start pulse and follows it to done; restart_at>0 fires a stray start mid-run.
  task automatic run_op(input string tag, input logic [2:0] m_v, input logic [7:0] a_v,
                        input logic [7:0] b_v, input logic ci, input int restart_at,
                        input logic [7:0] exp_res, input logic exp_co, input logic exp_er,
                        input logic exp_z, input int exp_lat);
    int cyc = 0;
    int busy_cyc = 0;
    logic got = 1'b0;
    logic stable = 1'b1;
    logic [7:0] held;
    logic [7:0] exp_v;
    logic [2:0] m_seen = 3'b000;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    held = result;
    m = m_v; a = a_v; b = b_v; cin = ci; start = 1'b1;
    while (!got && cyc < 30) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (restart_at != 0 && cyc == restart_at) begin
        start = 1'b1; m = 3'b011; a = ~a_v; b = 8'h00;
      end
      if (busy) busy_cyc++;
      if (cyc == 1) m_seen = alu_m;
      if (busy && !done && result !== held) stable = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    exp_v = exp_q.pop_front();
    check({tag, "_result"}, 32'(result), 32'(exp_v));
    check({tag, "_cout"}, 32'(cout), 32'(exp_co));
    check({tag, "_err"}, 32'(err), 32'(exp_er));
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    check({tag, "_result_held_in_run"}, 32'(stable), 32'd1);
    if (exp_lat > 1) check({tag, "_alu_m_in_run"}, 32'(m_seen), 32'(m_v));
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse_ends"}, 32'(done), 32'd0);
    check({tag, "_err_clears"}, 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Clock/reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_alu_m", 32'(alu_m), 32'd0);
    check("idle_alu_abc", 32'({alu_a, alu_b, alu_c}), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);

    // tag, M, a, b, cin, restart, result, cout, err, zero, latency
    run_op("add_5a_3c", 3'b000, 8'h5A, 8'h3C, 1'b0, 0, 8'h96, 1'b0, 1'b0, 1'b0, 9);
    run_op("add_ff_01_c", 3'b000, 8'hFF, 8'h01, 1'b1, 0, 8'h01, 1'b1, 1'b0, 1'b0, 9);
    run_op("illegal_110", 3'b110, 8'h77, 8'h11, 1'b1, 0, 8'h01, 1'b0, 1'b1, 1'b0, 1);
    run_op("and_f0_3c", 3'b001, 8'hF0, 8'h3C, 1'b1, 0, 8'h30, 1'b0, 1'b0, 1'b0, 9);
    run_op("or_0f_a0", 3'b010, 8'h0F, 8'hA0, 1'b0, 0, 8'hAF, 1'b0, 1'b0, 1'b0, 9);
    run_op("xnor_aa_0f", 3'b100, 8'hAA, 8'h0F, 1'b0, 0, 8'h5A, 1'b0, 1'b0, 1'b0, 9);
    run_op("xor_55_55", 3'b011, 8'h55, 8'h55, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 9);
    run_op("add_ignore_restart", 3'b000, 8'h12, 8'h34, 1'b0, 3, 8'h46, 1'b0, 1'b0, 1'b0, 9);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    m = 3'b000; a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy_before_rst", 32'(busy), 32'd1);
    check("midrun_alu_a_before_rst", 32'(alu_a), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_result", 32'(result), 32'd0);
    check("midrun_rst_cout", 32'(cout), 32'd0);
    check("midrun_rst_alu_m", 32'(alu_m), 32'd0);
    check("midrun_rst_alu_a", 32'(alu_a), 32'd0);
    check("midrun_rst_state", 32'(state_dbg), 32'd0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    check("midrun_rst_zero", 32'(zero), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after_rst", 3'b000, 8'h01, 8'h02, 1'b1, 0, 8'h04, 1'b0, 1'b0, 1'b0, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
